conv_window_scheduler: RTL and testbench

- Sequences the 5x5 convolution point datapath across a full feature map.
- For every valid output position (row, col), reads the 5x5 input window from a single-port map memory, one element per cycle.
- Presents the window and a start-captured kernel to the convolution point unit, then emits each result with a valid/ready handshake.
- Sits between the map buffer (memory read port) and the downstream output buffer or activation stage.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/convolution_point.sv | 36 +++
 rtl/conv_window_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants and types for the 5x5 convolution window
//               scheduler and its convolution point datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Kernel edge length and number of taps in one window
    localparam int KSIZE = 5;
    localparam int KTAPS = KSIZE * KSIZE;

    // Element width of the default window type
    localparam int WIN_BITWIDTH = 16;

    // Scheduler sequencing states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DRAIN   = 3'd2,
        S_COMPUTE = 3'd3,
        S_EMIT    = 3'd4,
        S_DONE    = 3'd5
    } conv_sched_state_t;

    // 5x5 window of signed elements; element (i, j) is win[i][j]
    typedef logic signed [KSIZE-1:0][KSIZE-1:0][WIN_BITWIDTH-1:0] window_t;

endpackage
`default_nettype wire

// File: rtl/convolution_point.sv
`default_nettype none
// ============================================================================
// Module      : convolution_point
// Description : Combinational 5x5 multiply-accumulate. Products are summed in
//               2*bitwidth, arithmetically shifted right and truncated
//               (wrapping) back to bitwidth.
// Revision    : 1.0 - initial release
// ============================================================================
module convolution_point
    import conv_pkg::*;
#(
    parameter int bitwidth = 16,
    parameter int shift    = 8
) (
    input  logic [KSIZE-1:0][KSIZE-1:0][bitwidth-1:0] window,
    input  logic [KSIZE-1:0][KSIZE-1:0][bitwidth-1:0] kernel,
    output logic signed [bitwidth-1:0]                result
);

    localparam int c_acc_w = 2 * bitwidth;

    logic signed [c_acc_w-1:0] w_acc;

    // Accumulate all 25 signed products, then scale and wrap to the output width
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                w_acc = w_acc + c_acc_w'($signed(window[i][j])) * c_acc_w'($signed(kernel[i][j]));
            end
        end
        result = bitwidth'(w_acc >>> shift);
    end

endmodule
`default_nettype wire

// File: rtl/conv_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_scheduler
// Description : Walks every valid 5x5 output position of a feature map,
//               fetches each window from a single-port memory one element
//               per cycle, runs it through convolution_point with a kernel
//               captured at start, and emits results over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_scheduler
    import conv_pkg::*;
#(
    parameter int BITWIDTH = 16,
    parameter int SHIFT    = 8,
    parameter int MAP_H    = 28,
    parameter int MAP_W    = 28,
    localparam int ADDR_W  = $clog2(MAP_H * MAP_W),
    localparam int ROW_W   = $clog2(MAP_H),
    localparam int COL_W   = $clog2(MAP_W)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [KSIZE-1:0][KSIZE-1:0][BITWIDTH-1:0] kernel,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      map_rd_en,
    output logic [ADDR_W-1:0]                         map_rd_addr,
    input  logic signed [BITWIDTH-1:0]                map_rd_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic signed [BITWIDTH-1:0]                out_data,
    output logic [ROW_W-1:0]                          out_row,
    output logic [COL_W-1:0]                          out_col
);

    // Map must hold at least one full window
    if (MAP_H < KSIZE) begin : g_chk_map_h
        $error("conv_window_scheduler: MAP_H must be >= 5");
    end
    if (MAP_W < KSIZE) begin : g_chk_map_w
        $error("conv_window_scheduler: MAP_W must be >= 5");
    end

    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(MAP_H - KSIZE);
    localparam logic [COL_W-1:0] c_last_col = COL_W'(MAP_W - KSIZE);
    localparam logic [2:0]       c_last_tap = 3'(KSIZE - 1);

    conv_sched_state_t r_state;
    conv_sched_state_t w_next_state;

    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [2:0]        r_ki;       // window row of the read being issued
    logic [2:0]        r_kj;       // window column of the read being issued
    logic [2:0]        r_wi;       // window slot for the data arriving now
    logic [2:0]        r_wj;
    logic              r_wr_pend;  // a read issued last cycle returns this cycle

    logic [KSIZE-1:0][KSIZE-1:0][BITWIDTH-1:0] r_window;
    logic [KSIZE-1:0][KSIZE-1:0][BITWIDTH-1:0] r_kernel;

    logic signed [BITWIDTH-1:0] r_out_data;
    logic [ROW_W-1:0]           r_out_row;
    logic [COL_W-1:0]           r_out_col;

    logic signed [BITWIDTH-1:0] w_point_result;
    logic [ADDR_W-1:0]          w_fetch_addr;
    logic                       w_fetch_last;
    logic                       w_last_pos;
    logic                       w_accept;
    logic                       w_handshake;

    assign w_fetch_last = (r_ki == c_last_tap) && (r_kj == c_last_tap);
    assign w_last_pos   = (r_row == c_last_row) && (r_col == c_last_col);
    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_handshake  = (r_state == S_EMIT) && out_ready;

    // Row-major address of window element (ki, kj) at position (row, col)
    assign w_fetch_addr = ADDR_W'((int'(r_row) + int'(r_ki)) * MAP_W + int'(r_col) + int'(r_kj));

    convolution_point #(
        .bitwidth (BITWIDTH),
        .shift    (SHIFT)
    ) u_point (
        .window (r_window),
        .kernel (r_kernel),
        .result (w_point_result)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next_state = S_FETCH;
            S_FETCH:   if (w_fetch_last) w_next_state = S_DRAIN;
            S_DRAIN:   w_next_state = S_COMPUTE;
            S_COMPUTE: w_next_state = S_EMIT;
            S_EMIT:    if (out_ready) w_next_state = w_last_pos ? S_DONE : S_FETCH;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs; the read address is parked at 0 outside FETCH
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        map_rd_en   = 1'b0;
        map_rd_addr = '0;
        out_valid   = 1'b0;
        case (r_state)
            S_FETCH: begin
                busy        = 1'b1;
                map_rd_en   = 1'b1;
                map_rd_addr = w_fetch_addr;
            end
            S_DRAIN, S_COMPUTE: busy = 1'b1;
            S_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Fetch tap counter: walks (ki, kj) row-major and wraps to 0 after the last tap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ki <= '0;
            r_kj <= '0;
        end else if (w_accept) begin
            r_ki <= '0;
            r_kj <= '0;
        end else if (r_state == S_FETCH) begin
            if (r_kj == c_last_tap) begin
                r_kj <= '0;
                r_ki <= (r_ki == c_last_tap) ? 3'd0 : r_ki + 3'd1;
            end else begin
                r_kj <= r_kj + 3'd1;
            end
        end
    end

    // Output position: advances row-major on each accepted result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_handshake && !w_last_pos) begin
            if (r_col != c_last_col) begin
                r_col <= r_col + COL_W'(1);
            end else begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end
        end
    end

    // Window fill: each read's data lands one cycle later in the slot it addressed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_pend <= 1'b0;
            r_wi      <= '0;
            r_wj      <= '0;
            r_window  <= '0;
        end else begin
            r_wr_pend <= (r_state == S_FETCH);
            r_wi      <= r_ki;
            r_wj      <= r_kj;
            if (r_wr_pend) begin
                r_window[r_wi][r_wj] <= map_rd_data;
            end
        end
    end

    // Kernel snapshot taken when a pass is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kernel <= '0;
        end else if (w_accept) begin
            r_kernel <= kernel;
        end
    end

    // Result register: loaded once per window, held through any backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_row  <= '0;
            r_out_col  <= '0;
        end else if (r_state == S_COMPUTE) begin
            r_out_data <= w_point_result;
            r_out_row  <= r_row;
            r_out_col  <= r_col;
        end
    end

    assign out_data = r_out_data;
    assign out_row  = r_out_row;
    assign out_col  = r_out_col;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_scheduler
// Description : Self-checking bench for conv_window_scheduler on a 6x7 map
//               with SHIFT=2. Table-driven passes, hand-written corner
//               sequences (backpressure, stray start, mid-pass reset) and
//               randomized passes against a direct convolution model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_scheduler;
    import conv_pkg::*;

    localparam int BW   = 16;
    localparam int SH   = 2;
    localparam int MH   = 6;
    localparam int MW   = 7;
    localparam int OW   = MW - 4;          // outputs per row
    localparam int NPOS = (MH - 4) * OW;   // outputs per pass
    localparam int AW   = $clog2(MH * MW);

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b1;
    logic                 start     = 1'b0;
    logic                 out_ready = 1'b0;
    window_t              kernel    = '0;
    logic                 busy;
    logic                 done;
    logic                 map_rd_en;
    logic [AW-1:0]        map_rd_addr;
    logic signed [BW-1:0] map_rd_data = '0;
    logic                 out_valid;
    logic signed [BW-1:0] out_data;
    logic [2:0]           out_row;
    logic [2:0]           out_col;

    conv_window_scheduler #(
        .BITWIDTH (BW),
        .SHIFT    (SH),
        .MAP_H    (MH),
        .MAP_W    (MW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .kernel      (kernel),
        .busy        (busy),
        .done        (done),
        .map_rd_en   (map_rd_en),
        .map_rd_addr (map_rd_addr),
        .map_rd_data (map_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col)
    );

    always #5 clk = ~clk;

    int                   mapv   [MH*MW];
    int                   kmodel [KSIZE][KSIZE];
    logic signed [BW-1:0] exp_d  [NPOS];
    int                   n_vec = 0;
    int                   n_err = 0;

    // Map memory with one-cycle read latency
    always @(posedge clk) begin
        if (map_rd_en) map_rd_data <= BW'(mapv[map_rd_addr]);
    end

    typedef struct {
        int                       map_mode;   // 0: all 4, 1: 4*addr, 2: all -1, 3: random
        int                       ker_mode;   // 0: all 1, 1: centre 1, 2: [0][0]=-1, 3: random
        int                       ready_mode; // 0: always ready, 1: random ready
        logic [NPOS-1:0][BW-1:0]  exp;
    } vec_t;

    vec_t vt [5];

    function automatic vec_t mk(input int mm, input int km, input int rm,
                                input int e0, input int e1, input int e2,
                                input int e3, input int e4, input int e5);
        vec_t v;
        v.map_mode   = mm;
        v.ker_mode   = km;
        v.ready_mode = rm;
        v.exp[0] = BW'(e0); v.exp[1] = BW'(e1); v.exp[2] = BW'(e2);
        v.exp[3] = BW'(e3); v.exp[4] = BW'(e4); v.exp[5] = BW'(e5);
        return v;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_scenario(input int mm, input int km);
        logic signed [BW-1:0] t;
        for (int a = 0; a < MH * MW; a++) begin
            case (mm)
                0:       mapv[a] = 4;
                1:       mapv[a] = 4 * a;
                2:       mapv[a] = -1;
                default: begin t = BW'($urandom); mapv[a] = t; end
            endcase
        end
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                case (km)
                    0:       kmodel[i][j] = 1;
                    1:       kmodel[i][j] = (i == 2 && j == 2) ? 1 : 0;
                    2:       kmodel[i][j] = (i == 0 && j == 0) ? -1 : 0;
                    default: begin t = BW'($urandom); kmodel[i][j] = t; end
                endcase
                kernel[i][j] = BW'(kmodel[i][j]);
            end
        end
    endtask

    // Direct 2-D convolution: 32-bit wrapping sum, arithmetic shift
    function automatic int ref_result(input int r, input int c);
        int acc;
        acc = 0;
        for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
                acc += mapv[(r + i) * MW + (c + j)] * kmodel[i][j];
        return acc >>> SH;
    endfunction

    // One full pass; call at #1 after a rising edge with the DUT idle.
    task automatic run_pass(input int ready_mode, input int first_stall, input bit disturb);
        int cyc, idx, stall_left, dones, done_cyc, last_hs;
        bit got_first;
        cyc = 0; idx = 0; dones = 0; done_cyc = -1; last_hs = -100;
        stall_left = first_stall; got_first = 1'b0;
        start = 1'b1;
        while (cyc < 3000 && done_cyc < 0) begin
            @(posedge clk); #1;
            cyc++;
            start     = (disturb && cyc == 5);
            out_ready = 1'b0;
            if (disturb && cyc == 10) begin
                for (int i = 0; i < KSIZE; i++)
                    for (int j = 0; j < KSIZE; j++)
                        kernel[i][j] = BW'($urandom);
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                check("done_busy_low", busy, 0);
            end
            if (out_valid && !got_first) begin
                got_first = 1'b1;
                check("first_valid_latency", cyc, 28);
            end
            if (got_first && stall_left > 0) begin
                check("stall_hold", {out_valid, map_rd_en, out_data, out_row, out_col},
                      {1'b1, 1'b0, exp_d[0], 3'd0, 3'd0});
                stall_left--;
            end else if (out_valid) begin
                out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (out_ready) begin
                    if (idx < NPOS) begin
                        check("out_data", out_data, exp_d[idx]);
                        check("out_row", out_row, idx / OW);
                        check("out_col", out_col, idx % OW);
                    end
                    idx++;
                    last_hs = cyc;
                end
            end
        end
        out_ready = 1'b0;
        check("result_count", idx, NPOS);
        check("done_count", dones, 1);
        check("done_after_last", done_cyc - last_hs, 1);
        start = disturb;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_cycle", {busy, done}, 0);
        @(posedge clk); #1;
        check("idle_after_done", {busy, done, out_valid}, 0);
    endtask

    initial begin
        int dones;

        vt[0] = mk(0, 0, 0,  25,  25,  25,  25,  25,  25);
        vt[1] = mk(1, 1, 1,  16,  17,  18,  23,  24,  25);
        vt[2] = mk(2, 0, 1,  -7,  -7,  -7,  -7,  -7,  -7);
        vt[3] = mk(1, 0, 0, 400, 425, 450, 575, 600, 625);
        vt[4] = mk(1, 2, 1,   0,  -1,  -2,  -7,  -8,  -9);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {busy, done, map_rd_en, map_rd_addr, out_valid, out_data, out_row, out_col}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven passes
        for (int v = 0; v < 5; v++) begin
            load_scenario(vt[v].map_mode, vt[v].ker_mode);
            for (int p = 0; p < NPOS; p++) exp_d[p] = vt[v].exp[p];
            run_pass(vt[v].ready_mode, 0, 1'b0);
        end

        // Ten-cycle backpressure on the first result
        load_scenario(1, 1);
        exp_d = '{16, 17, 18, 23, 24, 25};
        run_pass(0, 10, 1'b0);

        // Stray start mid-pass, kernel input scrambled mid-pass, start during DONE
        load_scenario(0, 0);
        exp_d = '{default: 25};
        run_pass(0, 0, 1'b1);

        // Asynchronous reset in cycle 40 of a pass
        load_scenario(1, 1);
        exp_d = '{16, 17, 18, 23, 24, 25};
        dones = 0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) dones++;
        end
        check("busy_before_rst", {busy, out_data}, {1'b1, 16'sd16});
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs",
              {busy, done, map_rd_en, map_rd_addr, out_valid, out_data, out_row, out_col}, 0);
        repeat (2) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("no_done_on_rst", dones, 0);
        run_pass(0, 0, 1'b0);

        // Random maps and kernels against the reference model
        for (int n = 0; n < 3; n++) begin
            load_scenario(3, 3);
            for (int p = 0; p < NPOS; p++) exp_d[p] = BW'(ref_result(p / OW, p % OW));
            run_pass(1, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
